wash_sequencer: RTL and testbench

WASH_SEQUENCER -- requirements
Module: wash_sequencer

---
 rtl/wash_sequencer_pkg.sv | 20 ++
 rtl/wash_phase_timer.sv | 20 ++
 rtl/wash_sequencer.sv | 136 +++++++++++++
 tb/tb_wash_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wash_sequencer_pkg.sv
// wash_sequencer_pkg: state encoding and default phase lengths for the wash sequencer
package wash_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_e;
  localparam int DEF_COIN_PRICE   = 2;
  localparam int DEF_SOAK_CYCLES  = 8;
  localparam int DEF_WASH_CYCLES  = 16;
  localparam int DEF_RINSE_CYCLES = 8;
  localparam int DEF_RINSE_PASSES = 2;
  localparam int DEF_SPIN_CYCLES  = 8;
  localparam int DEF_TIMER_W      = 8;
endpackage

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: loadable down-counter for phase durations; load beats enable
module wash_phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);
  logic [TIMER_W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : en ? count_q - TIMER_W'(1) : count_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign zero  = count_q == '0;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: coin-operated wash cycle controller with lid interlock and fault handling.
// Define WASH_BALANCE_RETRY_EN to allow two SPIN reloads on out-of-balance before faulting.
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int COIN_PRICE   = DEF_COIN_PRICE,
  parameter int SOAK_CYCLES  = DEF_SOAK_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int RINSE_PASSES = DEF_RINSE_PASSES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_Lid_Closed,
  input  logic               sig_Coin,
  input  logic               sig_Cancel,
  input  logic               sig_Out_Of_Balance,
  input  logic               sig_Motor_Failure,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] time_left,
  output logic [3:0]         rinse_pass,
  output logic               motor_on,
  output logic               water_valve,
  output logic               drain,
  output logic               busy,
  output logic               done,
  output logic               fault
);
  localparam int CW = $clog2(COIN_PRICE + 1);
  localparam logic [TIMER_W-1:0] SOAK_L  = TIMER_W'(SOAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WASH_L  = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RINSE_L = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPIN_L  = TIMER_W'(SPIN_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] coin_q, coin_d, coin_inc;
  logic [3:0] rp_q, rp_d;
  logic motor_q, motor_d, water_q, water_d, drain_q, drain_d;
  logic busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic ld, en, tz, phase, more_rinse;
  logic [TIMER_W-1:0] ld_val;
`ifdef WASH_BALANCE_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif
  wash_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock(clock), .reset(reset), .load(ld), .load_val(ld_val), .en(en),
    .count(time_left), .zero(tz)
  );
  assign phase      = state_q inside {S_SOAK, S_WASH, S_RINSE, S_SPIN};
  assign coin_inc   = coin_q == CW'(COIN_PRICE) ? coin_q : coin_q + CW'(1);
  assign more_rinse = (rp_q + 4'd1) < 4'(RINSE_PASSES);
  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rp_d    = rp_q;
    ld      = 1'b0;
    ld_val  = SPIN_L;
    en      = 1'b0;
`ifdef WASH_BALANCE_RETRY_EN
    retry_d = retry_q;
`endif
    if (sig_Motor_Failure && state_q != S_IDLE) state_d = S_FAULT;
    else if (sig_Cancel && state_q inside {S_IDLE, S_READY}) begin
      state_d = S_IDLE;
      coin_d  = '0;
    end else if (sig_Cancel && state_q inside {S_SOAK, S_WASH, S_RINSE}) begin
      state_d = S_SPIN;
      ld      = 1'b1;
    end else if (sig_Out_Of_Balance && state_q == S_SPIN) begin
`ifdef WASH_BALANCE_RETRY_EN
      state_d = retry_q == 2'd2 ? S_FAULT : S_SPIN;
      ld      = retry_q != 2'd2;
      retry_d = retry_q == 2'd2 ? retry_q : retry_q + 2'd1;
`else
      state_d = S_FAULT;
`endif
    end else if (phase && !sig_Lid_Closed) en = 1'b0;
    else if (phase && tz) begin
      // SPIN expiry leaves the timer parked at zero for DONE
      ld      = state_q != S_SPIN;
      state_d = state_q == S_SOAK ? S_WASH : state_q == S_WASH ? S_RINSE :
                state_q == S_RINSE ? (more_rinse ? S_RINSE : S_SPIN) : S_DONE;
      ld_val  = state_q == S_SOAK ? WASH_L : state_q == S_WASH ? RINSE_L :
                (state_q == S_RINSE && more_rinse) ? RINSE_L : SPIN_L;
      rp_d    = rp_q + 4'(state_q == S_RINSE);
`ifdef WASH_BALANCE_RETRY_EN
      retry_d = state_q == S_SPIN ? 2'd0 : retry_q;
`endif
    end else if (phase) en = 1'b1;
    else if (state_q == S_READY && sig_Lid_Closed) begin
      state_d = S_SOAK;
      ld      = 1'b1;
      ld_val  = SOAK_L;
    end else if (state_q == S_DONE && !sig_Lid_Closed) begin
      state_d = S_IDLE;
      coin_d  = '0;
      rp_d    = '0;
    end else if (state_q == S_IDLE && sig_Coin) begin
      coin_d  = coin_inc;
      state_d = coin_inc == CW'(COIN_PRICE) ? S_READY : S_IDLE;
    end
    motor_d = sig_Lid_Closed && state_d inside {S_WASH, S_RINSE, S_SPIN};
    water_d = sig_Lid_Closed && state_d inside {S_SOAK, S_RINSE};
    drain_d = sig_Lid_Closed && state_d == S_SPIN;
    busy_d  = state_d inside {S_SOAK, S_WASH, S_RINSE, S_SPIN};
    done_d  = state_d == S_DONE;
    fault_d = state_d == S_FAULT;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      coin_q  <= '0;
      rp_q    <= '0;
      {motor_q, water_q, drain_q, busy_q, done_q, fault_q} <= '0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rp_q    <= rp_d;
      {motor_q, water_q, drain_q, busy_q, done_q, fault_q} <=
        {motor_d, water_d, drain_d, busy_d, done_d, fault_d};
    end
`ifdef WASH_BALANCE_RETRY_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) retry_q <= '0;
    else retry_q <= retry_d;
`endif
  assign state       = state_q;
  assign rinse_pass  = rp_q;
  assign motor_on    = motor_q;
  assign water_valve = water_q;
  assign drain       = drain_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed checks of the wash sequencer with short phase lengths
module tb_wash_sequencer;
  logic clock = 1'b0, reset = 1'b1;
  logic lid = 1'b0, coin = 1'b0, cancel = 1'b0, oob = 1'b0, mfail = 1'b0;
  logic [2:0] state;
  logic [7:0] time_left;
  logic [3:0] rinse_pass;
  logic motor_on, water_valve, drain, busy, done, fault;
  int checks = 0, failures = 0;
  wash_sequencer #(
    .COIN_PRICE(2), .SOAK_CYCLES(3), .WASH_CYCLES(4), .RINSE_CYCLES(2),
    .RINSE_PASSES(2), .SPIN_CYCLES(3), .TIMER_W(8)
  ) dut (
    .clock(clock), .reset(reset), .sig_Lid_Closed(lid), .sig_Coin(coin),
    .sig_Cancel(cancel), .sig_Out_Of_Balance(oob), .sig_Motor_Failure(mfail),
    .state(state), .time_left(time_left), .rinse_pass(rinse_pass),
    .motor_on(motor_on), .water_valve(water_valve), .drain(drain),
    .busy(busy), .done(done), .fault(fault)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    {lid, coin, cancel, oob, mfail} = '0;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic start_cycle();
    lid = 1'b1;
    coin = 1'b1;
    tick(2);
    coin = 1'b0;
    tick(1);
  endtask
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({state, time_left, rinse_pass, motor_on, water_valve, drain, busy, done, fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs state=%0d tl=%0d rp=%0d act=%b%b%b flags=%b%b%b exp all 0",
               state, time_left, rinse_pass, motor_on, water_valve, drain, busy, done, fault);
    end
  endtask
  task automatic test_full_cycle();
    int es[15] = '{2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 6};
    int et[15] = '{2, 1, 0, 3, 2, 1, 0, 1, 0, 1, 0, 2, 1, 0, 0};
    int er[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
    apply_reset();
    lid = 1'b1;
    coin = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL coin1_state got=%0d exp=0", state); end
    tick(1);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL coin2_state got=%0d exp=1", state); end
    coin = 1'b0;
    for (int i = 0; i < 15; i++) begin
      logic em, ew, eb;
      tick(1);
      em = es[i] inside {3, 4, 5};
      ew = es[i] inside {2, 4};
      eb = es[i] inside {2, 3, 4, 5};
      checks++;
      if (state !== 3'(es[i]) || time_left !== 8'(et[i]) || rinse_pass !== 4'(er[i]) ||
          motor_on !== em || water_valve !== ew || busy !== eb || done !== (es[i] == 6)) begin
        failures++;
        $display("FAIL cycle_step%0d state=%0d tl=%0d rp=%0d m=%b w=%b b=%b d=%b exp state=%0d tl=%0d rp=%0d m=%b w=%b b=%b",
                 i, state, time_left, rinse_pass, motor_on, water_valve, busy, done,
                 es[i], et[i], er[i], em, ew, eb);
      end
    end
    lid = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0 || rinse_pass !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL done_to_idle state=%0d rp=%0d done=%b exp 0 0 0", state, rinse_pass, done);
    end
  endtask
  task automatic test_lid_freeze();
    apply_reset();
    start_cycle();
    tick(4);
    checks++;
    if (state !== 3'd3 || time_left !== 8'd2) begin
      failures++; $display("FAIL lid_pre state=%0d tl=%0d exp 3 2", state, time_left);
    end
    lid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (state !== 3'd3 || time_left !== 8'd2 || motor_on !== 1'b0) begin
        failures++;
        $display("FAIL lid_frozen%0d state=%0d tl=%0d motor=%b exp 3 2 0", i, state, time_left, motor_on);
      end
    end
    lid = 1'b1;
    tick(1);
    checks++;
    if (time_left !== 8'd1 || motor_on !== 1'b1) begin
      failures++; $display("FAIL lid_resume tl=%0d motor=%b exp 1 1", time_left, motor_on);
    end
    tick(1);
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL lid_wash_last got=%0d exp=3", state); end
    tick(1);
    checks++;
    if (state !== 3'd4) begin failures++; $display("FAIL lid_wash_end got=%0d exp=4", state); end
  endtask
  task automatic test_cancel();
    apply_reset();
    start_cycle();
    tick(7);
    checks++;
    if (state !== 3'd4 || rinse_pass !== 4'd0) begin
      failures++; $display("FAIL cancel_pre state=%0d rp=%0d exp 4 0", state, rinse_pass);
    end
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    checks++;
    if (state !== 3'd5 || time_left !== 8'd2 || drain !== 1'b1 || water_valve !== 1'b0) begin
      failures++;
      $display("FAIL cancel_spin state=%0d tl=%0d drain=%b water=%b exp 5 2 1 0", state, time_left, drain, water_valve);
    end
  endtask
  task automatic test_fault_priority();
    apply_reset();
    start_cycle();
    tick(3);
    mfail = 1'b1;
    cancel = 1'b1;
    tick(1);
    mfail = 1'b0;
    cancel = 1'b0;
    checks++;
    if (state !== 3'd7 || fault !== 1'b1 || motor_on !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fault_enter state=%0d fault=%b motor=%b busy=%b exp 7 1 0 0", state, fault, motor_on, busy);
    end
    tick(3);
    checks++;
    if (state !== 3'd7) begin failures++; $display("FAIL fault_sticky got=%0d exp=7", state); end
    reset = 1'b1;
    #1;
    checks++;
    if ({state, time_left, rinse_pass, motor_on, water_valve, drain, busy, done, fault} !== '0) begin
      failures++; $display("FAIL fault_async_reset state=%0d fault=%b exp 0 0", state, fault);
    end
    tick(1);
    reset = 1'b0;
  endtask
  task automatic test_balance();
    apply_reset();
    start_cycle();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd5 || time_left !== 8'd1) begin
      failures++; $display("FAIL bal_pre state=%0d tl=%0d exp 5 1", state, time_left);
    end
    oob = 1'b1;
`ifdef WASH_BALANCE_RETRY_EN
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if (state !== 3'd5 || time_left !== 8'd2) begin
        failures++; $display("FAIL bal_retry%0d state=%0d tl=%0d exp 5 2", i, state, time_left);
      end
    end
`endif
    tick(1);
    oob = 1'b0;
    checks++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      failures++; $display("FAIL bal_fault state=%0d fault=%b exp 7 1", state, fault);
    end
  endtask
  task automatic test_coin_cancel();
    apply_reset();
    mfail = 1'b1;
    tick(1);
    mfail = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      failures++; $display("FAIL idle_mfail state=%0d fault=%b exp 0 0", state, fault);
    end
    coin = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL coin3_state got=%0d exp=1", state); end
    coin = 1'b0;
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL ready_cancel got=%0d exp=0", state); end
    coin = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL coin_cleared got=%0d exp=0", state); end
    tick(1);
    coin = 1'b0;
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL coin_reready got=%0d exp=1", state); end
  endtask
  initial begin
    test_reset();
    test_full_cycle();
    test_lid_freeze();
    test_cancel();
    test_fault_priority();
    test_balance();
    test_coin_cancel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
